// File: rtl/mire_pkg.sv
// Shared types and helpers for the frame-buffer grid-pattern (mire) writer.
// Holds the FSM state encoding, the two pattern colours and the pixel function.
package mire_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [31:0] WHITE = 32'h00FF_FFFF;
  localparam logic [31:0] BLACK = 32'h0000_0000;

  // Grid lines fall on every multiple of grid; grid is a power of two, so a mask suffices.
  function automatic logic [31:0] pixel_colour(input logic [31:0] x,
                                               input logic [31:0] y,
                                               input logic [31:0] grid);
    logic [31:0] mask;
    mask = grid - 32'd1;
    return (((x & mask) == 32'd0) || ((y & mask) == 32'd0)) ? WHITE : BLACK;
  endfunction

endpackage

// File: rtl/mire_writer.sv
// Wishbone master that fills the frame buffer with a grid test pattern, one
// 32-bit word per pixel, releasing cyc for one cycle every BURST accepted writes.
module mire_writer
  import mire_pkg::*;
#(
  parameter int HDISP = 800,
  parameter int VDISP = 480,
  parameter int GRID  = 16,
  parameter int BURST = 64
) (
  input  logic        wshb_clk,
  input  logic        wshb_rst_n,
  input  logic        start,
  input  logic        continuous,
  output logic        busy,
  output logic        frame_done,
  output logic        wshb_cyc,
  output logic        wshb_stb,
  output logic        wshb_we,
  output logic [31:0] wshb_adr,
  output logic [31:0] wshb_dat_ms,
  output logic [3:0]  wshb_sel,
  output logic [2:0]  wshb_cti,
  output logic [1:0]  wshb_bte,
  input  logic        wshb_ack
);

  localparam int XW = (HDISP > 1) ? $clog2(HDISP) : 1;
  localparam int YW = (VDISP > 1) ? $clog2(VDISP) : 1;
  localparam int BW = $clog2(BURST + 1);

  localparam logic [XW-1:0] X_LAST = XW'(HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);

  state_e        state, state_nx;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [31:0]   adr;
  logic [BW-1:0] burst;

  logic accept;
  logic last_px;
  logic burst_full;

  // ack outside WRITE has no stb behind it and is ignored.
  assign accept     = (state == WRITE) && wshb_ack;
  assign last_px    = (x == X_LAST) && (y == Y_LAST);
  assign burst_full = (burst == B_LAST);

  // NOTE: every output of a combinational block gets a default before the case,
  // otherwise an unlisted path holds its old value and a latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start || continuous) state_nx = WRITE;
      WRITE: begin
        if (accept) begin
          if (last_px)         state_nx = DONE;
          else if (burst_full) state_nx = PAUSE;
        end
      end
      PAUSE: state_nx = WRITE;
      DONE:  state_nx = continuous ? WRITE : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order inside the block.
  always_ff @(posedge wshb_clk or negedge wshb_rst_n) begin
    if (!wshb_rst_n) begin
      state <= IDLE;
      x     <= '0;
      y     <= '0;
      adr   <= '0;
      burst <= '0;
    end else begin
      state <= state_nx;
      case (state)
        WRITE: begin
          if (accept) begin
            if (last_px) begin
              // The address never runs past the last pixel; the next frame starts at 0.
              x     <= '0;
              y     <= '0;
              adr   <= '0;
              burst <= '0;
            end else begin
              adr <= adr + 32'd4;
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 1'b1;
              end else begin
                x <= x + 1'b1;
              end
              burst <= burst_full ? '0 : burst + 1'b1;
            end
          end
        end
        IDLE, DONE: begin
          x     <= '0;
          y     <= '0;
          adr   <= '0;
          burst <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != IDLE);
  assign frame_done  = (state == DONE);
  assign wshb_cyc    = (state == WRITE);
  assign wshb_stb    = (state == WRITE);
  assign wshb_we     = (state == WRITE);
  assign wshb_adr    = adr;
  assign wshb_dat_ms = (state == WRITE) ? pixel_colour(32'(x), 32'(y), 32'(GRID)) : BLACK;
  assign wshb_sel    = 4'hF;
  assign wshb_cti    = 3'b000;
  assign wshb_bte    = 2'b00;

endmodule

// File: tb/tb_mire_writer.sv
// Scoreboard bench for mire_writer on a 32x4 frame: stimulus queues expected
// writes, a negedge monitor drives ack and checks every accepted write.
module tb_mire_writer;

  localparam int HDISP = 32;
  localparam int VDISP = 4;
  localparam int GRID  = 16;
  localparam int BURST = 64;
  localparam int N     = HDISP * VDISP;
  localparam int LAT   = 3;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
  } wr_t;

  logic        wshb_clk = 1'b0;
  logic        wshb_rst_n = 1'b0;
  logic        start = 1'b1;
  logic        continuous = 1'b0;
  logic        busy, frame_done;
  logic        wshb_cyc, wshb_stb, wshb_we;
  logic [31:0] wshb_adr, wshb_dat_ms;
  logic [3:0]  wshb_sel;
  logic [2:0]  wshb_cti;
  logic [1:0]  wshb_bte;
  logic        wshb_ack = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  wr_t         exp_q[$];
  logic [31:0] cap[N];
  bit          lat_mode = 1'b0;
  int          idx = 0;
  int          frames_seen = 0;
  int          cyc_n = 0;
  int          first_stb = 0;
  int          wait_cnt = 0;
  bit          prev_wait = 1'b0;
  logic [31:0] prev_adr, prev_dat;

  mire_writer #(.HDISP(HDISP), .VDISP(VDISP), .GRID(GRID), .BURST(BURST)) dut (
    .wshb_clk    (wshb_clk),
    .wshb_rst_n  (wshb_rst_n),
    .start       (start),
    .continuous  (continuous),
    .busy        (busy),
    .frame_done  (frame_done),
    .wshb_cyc    (wshb_cyc),
    .wshb_stb    (wshb_stb),
    .wshb_we     (wshb_we),
    .wshb_adr    (wshb_adr),
    .wshb_dat_ms (wshb_dat_ms),
    .wshb_sel    (wshb_sel),
    .wshb_cti    (wshb_cti),
    .wshb_bte    (wshb_bte),
    .wshb_ack    (wshb_ack)
  );

  always #5 wshb_clk = ~wshb_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_pixel(input int x, input int y);
    return ((x % GRID == 0) || (y % GRID == 0)) ? 32'h00FF_FFFF : 32'h0;
  endfunction

  task automatic push_frame();
    for (int i = 0; i < N; i++) begin
      wr_t e;
      e.adr = 32'(i * 4);
      e.dat = model_pixel(i % HDISP, i / HDISP);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start();
    @(negedge wshb_clk);
    start = 1'b1;
    @(negedge wshb_clk);
    start = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int c = 0; c < budget && frames_seen < target; c++) @(posedge wshb_clk);
    if (frames_seen < target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL frame_timeout: got %0d frames expected %0d", frames_seen, target);
    end
    #1;
  endtask

  // Monitor and ack responder: ack is decided first, then an accepted write is the
  // cycle where cyc, stb and ack are all high ahead of the coming posedge.
  always @(negedge wshb_clk) begin
    cyc_n++;
    if (!wshb_rst_n) begin
      idx       = 0;
      wait_cnt  = 0;
      prev_wait = 1'b0;
    end else begin
      if (!lat_mode) begin
        wshb_ack = 1'b1;
      end else if (wshb_cyc && wshb_stb) begin
        wait_cnt++;
        wshb_ack = (wait_cnt == LAT);
        if (wshb_ack) wait_cnt = 0;
      end else begin
        wshb_ack = 1'b0;
        wait_cnt = 0;
      end

      if (prev_wait) begin
        check("hold_cyc_stb", 32'({wshb_cyc, wshb_stb}), 32'd3);
        check("hold_adr", wshb_adr, prev_adr);
        check("hold_dat", wshb_dat_ms, prev_dat);
      end
      prev_wait = lat_mode && wshb_cyc && wshb_stb && !wshb_ack;
      prev_adr  = wshb_adr;
      prev_dat  = wshb_dat_ms;

      if (wshb_cyc && wshb_stb && wshb_ack) begin
        check("we", 32'(wshb_we), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got adr %h expected no write", wshb_adr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("adr", wshb_adr, e.adr);
          check("dat", wshb_dat_ms, e.dat);
        end
        if (idx == 0) first_stb = cyc_n;
        else if (!lat_mode) check("write_timing", 32'(cyc_n - first_stb), 32'(idx + idx / BURST));
        if (idx < N) cap[idx] = wshb_dat_ms;
        idx++;
      end

      if (frame_done) begin
        frames_seen++;
        check("writes_per_frame", 32'(idx), 32'(N));
        check("busy_at_done", 32'(busy), 32'd1);
        check("cyc_at_done", 32'(wshb_cyc), 32'd0);
        if (!lat_mode) check("frame_len", 32'(cyc_n - first_stb + 1), 32'(N + (N - 1) / BURST + 1));
        idx = 0;
      end
    end
  end

  initial begin
    int f0;

    // Reset held with start and ack both high.
    repeat (3) @(posedge wshb_clk);
    #1;
    check("rst_cyc", 32'(wshb_cyc), 32'd0);
    check("rst_stb", 32'(wshb_stb), 32'd0);
    check("rst_we", 32'(wshb_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_adr", wshb_adr, 32'd0);
    check("rst_dat", wshb_dat_ms, 32'd0);
    check("rst_sel", 32'(wshb_sel), 32'hF);
    check("rst_cti", 32'(wshb_cti), 32'd0);
    check("rst_bte", 32'(wshb_bte), 32'd0);
    check("rst_no_write", 32'(idx), 32'd0);
    @(negedge wshb_clk);
    start = 1'b0;
    @(negedge wshb_clk);
    wshb_rst_n = 1'b1;
    repeat (3) @(posedge wshb_clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    // Single frame, ack tied high.
    push_frame();
    pulse_start();
    wait_frames(1, 400);
    check("after_frame_busy", 32'(busy), 32'd0);
    check("after_frame_queue", 32'(exp_q.size()), 32'd0);
    check("pix_0_0", cap[0], 32'h00FF_FFFF);
    check("pix_1_1", cap[1 * HDISP + 1], 32'h0);
    check("pix_16_3", cap[3 * HDISP + 16], 32'h00FF_FFFF);
    check("pix_5_0", cap[5], 32'h00FF_FFFF);
    check("pix_17_2", cap[2 * HDISP + 17], 32'h0);

    // Multi-cycle ack latency.
    @(negedge wshb_clk);
    lat_mode = 1'b1;
    push_frame();
    pulse_start();
    wait_frames(2, 1500);
    check("lat_queue", 32'(exp_q.size()), 32'd0);
    @(negedge wshb_clk);
    lat_mode = 1'b0;
    repeat (2) @(negedge wshb_clk);

    // Continuous mode, then stop with start pulses ignored while busy.
    f0 = frames_seen;
    push_frame();
    push_frame();
    @(negedge wshb_clk);
    continuous = 1'b1;
    wait_frames(f0 + 1, 400);
    check("cont_busy_kept", 32'(busy), 32'd1);
    @(negedge wshb_clk);
    continuous = 1'b0;
    repeat (10) @(negedge wshb_clk);
    pulse_start();
    repeat (20) @(negedge wshb_clk);
    pulse_start();
    wait_frames(f0 + 2, 400);
    check("cont_stop_busy", 32'(busy), 32'd0);
    repeat (20) @(posedge wshb_clk);
    #1;
    check("cont_no_restart", 32'(frames_seen), 32'(f0 + 2));
    check("cont_idle_cyc", 32'(wshb_cyc), 32'd0);
    check("cont_queue", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame at write 70.
    f0 = frames_seen;
    push_frame();
    pulse_start();
    for (int c = 0; c < 400 && idx < 70; c++) @(posedge wshb_clk);
    check("abort_reached_70", 32'(idx), 32'd70);
    #2;
    wshb_rst_n = 1'b0;
    #1;
    check("abort_cyc_async", 32'(wshb_cyc), 32'd0);
    check("abort_stb_async", 32'(wshb_stb), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge wshb_clk);
    #1;
    check("abort_no_done", 32'(frames_seen), 32'(f0));
    @(negedge wshb_clk);
    wshb_rst_n = 1'b1;
    push_frame();
    pulse_start();
    wait_frames(f0 + 1, 400);
    check("restart_queue", 32'(exp_q.size()), 32'd0);
    check("restart_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mire_writer.md
Name: mire_writer

Overview:
- Wishbone master in the SDRAM bus domain that fills the frame buffer with a grid test pattern (mire).
- It is the upstream stage of the video readout: it writes HDISP*VDISP 32-bit pixel words at byte addresses 0 .. 4*(HDISP*VDISP-1).
- The video controller streams these same addresses to the screen.
- It throttles itself with periodic idle cycles so the bus arbiter can serve the video reader.

Parameters:
- HDISP, 800, displayed pixels per line.
- VDISP, 480, displayed lines per frame.
- GRID, 16, grid pitch in pixels. Must be a power of two.
- BURST, 64, maximum consecutive accepted writes before a forced 1-cycle release of cyc.

Ports:
- wshb_clk  in  1  bus clock (100 MHz).
- wshb_rst_n  in  1  reset; one clock domain, asynchronous assertion, active-low.
- start  in  1  single-cycle request to write one frame; ignored while busy=1.
- continuous  in  1  when 1, restart automatically after each frame.
- busy  out  1  high from frame start until frame_done.
- frame_done  out  1  one-cycle pulse after the last write is acknowledged.
- wshb_cyc  out  1  Wishbone cycle.
- wshb_stb  out  1  Wishbone strobe.
- wshb_we  out  1  write enable; constant 1 during a request.
- wshb_adr  out  32  byte address.
- wshb_dat_ms  out  32  write data.
- wshb_sel  out  4  byte enables; 4'hF.
- wshb_cti  out  3  cycle type; 3'b000 (classic).
- wshb_bte  out  2  burst type; 2'b00.
- wshb_ack  in  1  slave acknowledge.

Behaviour:
- Reset (wshb_rst_n=0, asynchronous):
  - State = IDLE; x, y, adr and the burst counter = 0.
  - cyc, stb, we, busy and frame_done = 0; dat_ms = 0.
  - sel = 4'hF, cti = 0, bte = 0 at all times.
  - Reset mid-frame aborts immediately; no frame_done is produced.
- States IDLE, WRITE, PAUSE, DONE.
  - IDLE:
    - start=1 or continuous=1 -> WRITE next cycle.
    - x = y = adr = burst count = 0; busy rises with the WRITE entry.
  - WRITE:
    - cyc = stb = we = 1.
    - adr = 4*(y*HDISP + x), held as a running counter, not a multiplier.
    - dat_ms = pixel(x,y).
    - All outputs are held stable until ack=1. A classic cycle can have multi-cycle ack latency.
  - On ack in WRITE:
    - adr += 4; x += 1.
    - If x == HDISP-1: x = 0 and y += 1.
    - Burst count += 1.
  - Ack that is also the last pixel (x=HDISP-1, y=VDISP-1) -> DONE. This takes priority over PAUSE.
  - Otherwise, ack that brings the burst count to BURST -> PAUSE, with the burst count cleared.
  - PAUSE: exactly one cycle with cyc = stb = 0, then WRITE.
  - DONE:
    - frame_done = 1 for one cycle; cyc = stb = 0.
    - Next state is WRITE with counters cleared if continuous=1. busy stays 1 and there is no extra idle cycle beyond DONE.
    - Otherwise next state is IDLE and busy = 0.
- ack while stb=0 is ignored.
- pixel(x,y):
  - 32'h00FFFFFF if x[log2 GRID-1:0]==0 or y[log2 GRID-1:0]==0.
  - 32'h00000000 otherwise.
  - The upper byte is always 0; RGB occupies bits [23:0].
- Throughput with ack every cycle:
  - One word per cycle, except one lost cycle every BURST words.
  - Frame length = N + floor((N-1)/BURST) + 1 cycles from the first stb to frame_done, where N = HDISP*VDISP.
- Counter widths: x is $clog2(HDISP), y is $clog2(VDISP). No wrap beyond the last address; the next frame restarts at 0.
- start asserted while busy=1 has no effect. It is not queued.

Decomposition:
- Package mire_pkg:
  - State enum (IDLE, WRITE, PAUSE, DONE).
  - Colour constants WHITE = 32'h00FFFFFF and BLACK = 32'h0.
  - A pure function for the pixel colour from x, y and GRID.
- No sub-module: x/y/adr/burst counters and the FSM live in one module.

Test Plan:
- Reset values: hold wshb_rst_n=0 with start=1 and ack=1. -> cyc = stb = busy = frame_done = 0, adr = 0, sel = F, cti = 0; no transaction.
- Small frame: HDISP=32, VDISP=4, GRID=16, BURST=64. Pulse start; ack tied high. -> 128 writes at addresses 0..508 step 4; a cyc=0 gap after write 64; frame_done after write 128; 130 cycles from first stb; then busy=0.
- Ack latency 3 cycles. -> adr, dat_ms, cyc and stb are stable across wait cycles; exactly one address increment per ack.
- Pattern check. -> (0,0) = 00FFFFFF; (1,1) = 0; (16,3) = 00FFFFFF; (5,0) = 00FFFFFF; (17,2) = 0.
- continuous=1 -> after frame_done the next stb is at adr = 0 with busy staying 1. Then continuous=0 with start pulses while busy -> ignored; stop after the current frame.
- Assert wshb_rst_n=0 at write 70. -> cyc drops asynchronously and no frame_done occurs. After release plus start, writing resumes at adr = 0.
